// File: rtl/attr_interp_seq_if.sv
// Request/result bundle for attr_interp_seq. The o_sat member exists only
// when ATTR_INTERP_SAT_EN is defined.
interface attr_interp_seq_if #(
  parameter int unsigned ATTR_WIDTH   = 32,
  parameter int unsigned WEIGHT_WIDTH = 22,
  parameter int unsigned NUM_ATTRS    = 4
);
  localparam int unsigned VW = NUM_ATTRS * ATTR_WIDTH;

  logic                    i_valid;
  logic                    o_ready;
  logic [VW-1:0]           i_attr0;
  logic [VW-1:0]           i_attr1;
  logic [VW-1:0]           i_attr2;
  logic [WEIGHT_WIDTH-1:0] i_lambda0;
  logic [WEIGHT_WIDTH-1:0] i_lambda1;
  logic [WEIGHT_WIDTH-1:0] i_lambda2;
  logic                    o_valid;
  logic                    i_ready;
  logic [VW-1:0]           o_attr;
`ifdef ATTR_INTERP_SAT_EN
  logic [NUM_ATTRS-1:0]    o_sat;
`endif

  modport slave (
    input  i_valid, i_attr0, i_attr1, i_attr2, i_lambda0, i_lambda1, i_lambda2, i_ready,
`ifdef ATTR_INTERP_SAT_EN
    output o_sat,
`endif
    output o_ready, o_valid, o_attr
  );

  modport master (
    output i_valid, i_attr0, i_attr1, i_attr2, i_lambda0, i_lambda1, i_lambda2, i_ready,
`ifdef ATTR_INTERP_SAT_EN
    input  o_sat,
`endif
    input  o_ready, o_valid, o_attr
  );
endinterface

// File: rtl/attr_interp_seq.sv
// Sequential barycentric attribute interpolator, one channel per cycle.
// Define ATTR_INTERP_SAT_EN to clamp out-of-range results and expose o_sat.
module attr_interp_seq #(
  parameter int unsigned ATTR_WIDTH   = 32,
  parameter int unsigned WEIGHT_WIDTH = 22,
  parameter int unsigned FRAC_BITS    = 20,
  parameter int unsigned NUM_ATTRS    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  attr_interp_seq_if.slave  bus
);
  localparam int unsigned AW = ATTR_WIDTH;
  localparam int unsigned WW = WEIGHT_WIDTH;
  localparam int unsigned SW = AW + WW + 2;
  localparam int unsigned VW = NUM_ATTRS * AW;
  localparam int unsigned CW = (NUM_ATTRS > 1) ? $clog2(NUM_ATTRS) : 1;

  localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC_BITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q;
  logic [CW-1:0]        cnt_q;
  logic [VW-1:0]        a0_q, a1_q, a2_q;
  logic signed [WW-1:0] l0_q, l1_q, l2_q;
  logic [VW-1:0]        attr_q;
  logic [NUM_ATTRS-1:0] sat_q;

  logic signed [AW-1:0] ch_a0, ch_a1, ch_a2;
  logic signed [SW-1:0] sum, rounded;
  logic [AW-1:0]        res;
  logic                 clip;
  logic                 unused_hi;

  always_comb begin
    ch_a0   = a0_q[cnt_q*AW +: AW];
    ch_a1   = a1_q[cnt_q*AW +: AW];
    ch_a2   = a2_q[cnt_q*AW +: AW];
    // Full-width sign-extended products; three terms cannot overflow SW bits.
    sum     = SW'(ch_a0) * SW'(l0_q) + SW'(ch_a1) * SW'(l1_q) + SW'(ch_a2) * SW'(l2_q);
    rounded = (sum + HALF) >>> FRAC_BITS;
    res     = rounded[AW-1:0];
    clip    = 1'b0;
    unused_hi = ^rounded[SW-1:AW];
`ifdef ATTR_INTERP_SAT_EN
    // Fits only when all bits from the ATTR_WIDTH sign bit upward agree.
    if (!((&rounded[SW-1:AW-1]) || !(|rounded[SW-1:AW-1]))) begin
      clip = 1'b1;
      res  = rounded[SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      l0_q    <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      attr_q  <= '0;
      sat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            a0_q    <= bus.i_attr0;
            a1_q    <= bus.i_attr1;
            a2_q    <= bus.i_attr2;
            l0_q    <= bus.i_lambda0;
            l1_q    <= bus.i_lambda1;
            l2_q    <= bus.i_lambda2;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          attr_q[cnt_q*AW +: AW] <= res;
          sat_q[cnt_q]           <= clip;
          if (cnt_q == CW'(NUM_ATTRS - 1)) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_attr  = attr_q;
`ifdef ATTR_INTERP_SAT_EN
  assign bus.o_sat   = sat_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat_q;
`endif
endmodule

// File: tb/tb_attr_interp_seq.sv
// Directed bench for attr_interp_seq with hand-computed expectations.
// Honours ATTR_INTERP_SAT_EN for the overflow and o_sat checks.
module tb_attr_interp_seq;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 22;
  localparam int unsigned FB = 20;
  localparam int unsigned NA = 4;
  localparam logic [WW-1:0] UNIT = 22'd1048576;
  localparam logic [WW-1:0] HALFW = 22'd524288;
  localparam logic [WW-1:0] QUART = 22'd262144;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  attr_interp_seq_if #(.ATTR_WIDTH(AW), .WEIGHT_WIDTH(WW), .NUM_ATTRS(NA)) bus ();

  attr_interp_seq #(
    .ATTR_WIDTH(AW), .WEIGHT_WIDTH(WW), .FRAC_BITS(FB), .NUM_ATTRS(NA)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_frag(input logic [127:0] a0, input logic [127:0] a1, input logic [127:0] a2,
                          input logic [WW-1:0] l0, input logic [WW-1:0] l1,
                          input logic [WW-1:0] l2);
    bus.i_attr0   = a0;
    bus.i_attr1   = a1;
    bus.i_attr2   = a2;
    bus.i_lambda0 = l0;
    bus.i_lambda1 = l1;
    bus.i_lambda2 = l2;
  endtask

  // Called one cycle after acceptance; ends in the first o_valid cycle (T+5).
  task automatic wait_done(input string tag);
    for (int i = 1; i < 5; i++) begin
      chk({tag, "_busy_valid"}, 128'(bus.o_valid), 128'(1'b0));
      chk({tag, "_busy_ready"}, 128'(bus.o_ready), 128'(1'b0));
      tick();
    end
    chk({tag, "_valid_T5"}, 128'(bus.o_valid), 128'(1'b1));
  endtask

  logic [127:0] exp_c, exp_hold;
  logic [127:0] exp_b2b [3];

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b1;  // reset must win over a pending request
    bus.i_ready = 1'b0;
    set_frag('1, '1, '1, UNIT, UNIT, UNIT);
    tick();
    tick();
    chk("reset_ready", 128'(bus.o_ready), 128'(1'b1));
    chk("reset_valid", 128'(bus.o_valid), 128'(1'b0));
    chk("reset_attr", bus.o_attr, '0);
`ifdef ATTR_INTERP_SAT_EN
    chk("reset_sat", 128'(bus.o_sat), '0);
`endif
    bus.i_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_ready", 128'(bus.o_ready), 128'(1'b1));

    // Unit weight on vertex 0; vertex 1/2 data must not leak in.
    set_frag(pack4(32'd100, 32'd200, -32'sd300, 32'd7),
             pack4(32'd12345, 32'd1, 32'd2, 32'd3),
             pack4(-32'sd999, 32'd5, 32'd6, 32'd8), UNIT, '0, '0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    set_frag('1, '1, '1, UNIT, UNIT, UNIT);  // post-acceptance change must be ignored
    wait_done("unit");
    chk("unit_attr", bus.o_attr, pack4(32'd100, 32'd200, -32'sd300, 32'd7));
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("unit_after_valid", 128'(bus.o_valid), 128'(1'b0));
    chk("unit_after_ready", 128'(bus.o_ready), 128'(1'b1));

    // Rounding: half toward +inf with arithmetic shift.
    set_frag(pack4(32'd10, -32'sd7, 32'd5, 32'd1),
             pack4(32'd11, 32'd0, -32'sd6, 32'd2), '0, HALFW, HALFW, '0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    wait_done("round");
    chk("round_attr", bus.o_attr, pack4(32'd11, -32'sd3, 32'd0, 32'd2));
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Backpressure: negated vertex 2, held 6 cycles, request pulses ignored.
    set_frag('0, '0, pack4(32'd1, 32'd2, 32'd3, 32'd4), '0, '0, -UNIT);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    wait_done("bp");
    exp_hold = pack4(-32'sd1, -32'sd2, -32'sd3, -32'sd4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_attr", bus.o_attr, exp_hold);
      chk("bp_valid", 128'(bus.o_valid), 128'(1'b1));
      chk("bp_ready", 128'(bus.o_ready), 128'(1'b0));
      bus.i_valid = (i % 2 == 0);
      set_frag(pack4(32'd9, 32'd9, 32'd9, 32'd9), '0, '0, UNIT, '0, '0);
      tick();
    end
    bus.i_valid = 1'b0;
    chk("bp_attr_end", bus.o_attr, exp_hold);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("bp_done_valid", 128'(bus.o_valid), 128'(1'b0));
    chk("bp_done_ready", 128'(bus.o_ready), 128'(1'b1));
    tick();
    chk("bp_no_capture", 128'(bus.o_ready), 128'(1'b1));

    // Overflow: positive on ch0/1, negative on ch2/3.
    set_frag(pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000),
             pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000), '0,
             UNIT, UNIT, '0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    wait_done("ovf");
`ifdef ATTR_INTERP_SAT_EN
    chk("ovf_attr", bus.o_attr, pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000));
    chk("ovf_sat", 128'(bus.o_sat), 128'(4'hF));
`else
    chk("ovf_attr", bus.o_attr, pack4(32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 32'h0));
`endif
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Reset during the second CALC cycle abandons the fragment.
    set_frag(pack4(32'd100, 32'd200, -32'sd300, 32'd7), '0, '0, UNIT, '0, '0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    tick();
    rst = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ready = 1'b0;
    chk("rstmid_ready", 128'(bus.o_ready), 128'(1'b1));
    chk("rstmid_valid", 128'(bus.o_valid), 128'(1'b0));
    chk("rstmid_attr", bus.o_attr, '0);
`ifdef ATTR_INTERP_SAT_EN
    chk("rstmid_sat", 128'(bus.o_sat), '0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstmid_quiet", 128'(bus.o_valid), 128'(1'b0));
    end
    set_frag(pack4(32'd10, -32'sd7, 32'd5, 32'd1),
             pack4(32'd11, 32'd0, -32'sd6, 32'd2), '0, HALFW, HALFW, '0);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    wait_done("rstnew");
    chk("rstnew_attr", bus.o_attr, pack4(32'd11, -32'sd3, 32'd0, 32'd2));
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Back-to-back: three fragments, results 6 cycles apart.
    exp_b2b[0] = pack4(32'd225, 32'd4, -32'sd2, 32'd0);
    exp_b2b[1] = pack4(32'd5, 32'd6, 32'd7, 32'd8);
    exp_b2b[2] = pack4(32'd5, -32'sd5, 32'd2, -32'sd1);
    set_frag(pack4(32'd100, 32'd4, -32'sd8, 32'd1), pack4(32'd200, 32'd4, 32'd0, 32'd0),
             pack4(32'd300, 32'd4, 32'd0, 32'd0), QUART, QUART, HALFW);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    for (int t = 1; t < 18; t++) begin
      tick();
      if (t == 1) set_frag('0, pack4(32'd5, 32'd6, 32'd7, 32'd8), '0, '0, UNIT, '0);
      if (t == 7) set_frag('0, '0, pack4(32'd10, -32'sd10, 32'd3, -32'sd3), '0, '0, HALFW);
      if (t == 17) bus.i_valid = 1'b0;
      chk("b2b_valid", 128'(bus.o_valid), 128'(t % 6 == 5));
      if (t % 6 == 5) begin
        exp_c = exp_b2b[t / 6];
        chk("b2b_attr", bus.o_attr, exp_c);
      end
    end
    tick();
    bus.i_ready = 1'b0;
    chk("b2b_end_ready", 128'(bus.o_ready), 128'(1'b1));
    tick();
    chk("b2b_end_idle", 128'(bus.o_ready), 128'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
